stall_ctrl: RTL and testbench

- Decode-stage hazard controller that sequences the ID-stage branch comparator and the rest of the 5-stage MIPS pipeline.
- Keeps an internal E/M scoreboard of destination registers and Tnew values, compares it against the Tuse of the instruction in D, and asserts stall when an operand is not ready.
- Owns the multiply/divide busy timer and stalls any HI/LO-class instruction while the unit is occupied.
- Also provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/stall_ctrl.sv | 139 +++++++++++++
 tb/tb_stall_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Purpose: decode-stage hazard controller; E/M Tnew scoreboard vs D Tuse, MD busy timer, stall counter.
// Latency: stall is combinational from D inputs and registered state; scoreboard/timer update on the next edge.
// Backpressure: stall freezes PC and D and loads a bubble into E; the W stage never stalls.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   d_valid, d_rs, d_rt        D instruction presence and source registers
//   d_tuse_rs, d_tuse_rt       cycles until each source is consumed (3 = not used)
//   d_dest, d_tnew             D destination (0 = none) and Tnew on E entry
//   d_md_start, d_md_div       D starts a mult/div; d_md_div selects divide
//   d_md_use                   D touches HI/LO or the MD unit
//   stall, pc_en, d_en, e_clr  stall request and derived pipeline enables
//   br_stall                   stall caused by an operand needed in ID (tuse 0)
//   md_busy, stall_cnt         MD unit occupied; saturating stall-cycle counter
module stall_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4,
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  logic [4:0]        d_rs,
   input  logic [4:0]        d_rt,
   input  logic [1:0]        d_tuse_rs,
   input  logic [1:0]        d_tuse_rt,
   input  logic [4:0]        d_dest,
   input  logic [1:0]        d_tnew,
   input  logic              d_md_start,
   input  logic              d_md_div,
   input  logic              d_md_use,
   output logic              stall,
   output logic              pc_en,
   output logic              d_en,
   output logic              e_clr,
   output logic              br_stall,
   output logic              md_busy,
   output logic [PERF_W-1:0] stall_cnt
);

   // E/M scoreboard
   logic [4:0]        e_dest_q,     e_dest_d;
   logic [1:0]        e_tnew_q,     e_tnew_d;
   logic              e_md_start_q, e_md_start_d;
   logic              e_md_div_q,   e_md_div_d;
   logic [4:0]        m_dest_q,     m_dest_d;
   logic [1:0]        m_tnew_q,     m_tnew_d;

   // MD busy timer and performance counter
   logic [CNT_W-1:0]  md_cnt_q,     md_cnt_d;
   logic [PERF_W-1:0] stall_cnt_q,  stall_cnt_d;

   logic haz_rs;
   logic haz_rt;
   logic haz_md;
   logic busy_raw;

   // Hazard detection. Register 0 and tuse 3 never match. W is never compared:
   // anything in W is forwarded from the register file write in time.
   always_comb begin
      haz_rs = d_valid && (d_rs != 5'd0) && (d_tuse_rs != 2'd3) &&
               (((d_rs == e_dest_q) && (d_tuse_rs < e_tnew_q)) ||
                ((d_rs == m_dest_q) && (d_tuse_rs < m_tnew_q)));
      haz_rt = d_valid && (d_rt != 5'd0) && (d_tuse_rt != 2'd3) &&
               (((d_rt == e_dest_q) && (d_tuse_rt < e_tnew_q)) ||
                ((d_rt == m_dest_q) && (d_tuse_rt < m_tnew_q)));
      busy_raw = (md_cnt_q != '0);
      // A start still sitting in E has not loaded the timer yet, so it counts as busy.
      haz_md = d_valid && d_md_use && (busy_raw || e_md_start_q);
   end

   // Outputs are forced to the cleared state while reset is held, even before
   // the first reset edge has cleared the registers.
   always_comb begin
      stall     = !reset && (haz_rs || haz_rt || haz_md);
      br_stall  = !reset && ((haz_rs && (d_tuse_rs == 2'd0)) ||
                             (haz_rt && (d_tuse_rt == 2'd0)));
      md_busy   = !reset && busy_raw;
      pc_en     = !stall;
      d_en      = !stall;
      e_clr     = stall;
      stall_cnt = stall_cnt_q;
   end

   // Next-state logic
   always_comb begin
      e_dest_d     = 5'd0;
      e_tnew_d     = 2'd0;
      e_md_start_d = 1'b0;
      e_md_div_d   = 1'b0;
      if (!stall && d_valid) begin
         e_dest_d     = d_dest;
         e_tnew_d     = d_tnew;
         e_md_start_d = d_md_start;
         e_md_div_d   = d_md_start && d_md_div;
      end

      m_dest_d = e_dest_q;
      m_tnew_d = (e_tnew_q != 2'd0) ? (e_tnew_q - 2'd1) : 2'd0;

      // A new start is always held in D while busy, so the load never
      // overwrites a running count.
      md_cnt_d = md_cnt_q;
      if (e_md_start_q) begin
         md_cnt_d = e_md_div_q ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_dest_q     <= 5'd0;
         e_tnew_q     <= 2'd0;
         e_md_start_q <= 1'b0;
         e_md_div_q   <= 1'b0;
         m_dest_q     <= 5'd0;
         m_tnew_q     <= 2'd0;
         md_cnt_q     <= '0;
         stall_cnt_q  <= '0;
      end else begin
         e_dest_q     <= e_dest_d;
         e_tnew_q     <= e_tnew_d;
         e_md_start_q <= e_md_start_d;
         e_md_div_q   <= e_md_div_d;
         m_dest_q     <= m_dest_d;
         m_tnew_q     <= m_tnew_d;
         md_cnt_q     <= md_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed-vector bench for stall_ctrl: each driven cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares. A second instance with a
// 4-bit stall counter shares all inputs to exercise saturation.
module tb_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        d_valid;
   logic [4:0]  d_rs, d_rt, d_dest;
   logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
   logic        d_md_start, d_md_div, d_md_use;

   logic        stall, pc_en, d_en, e_clr, br_stall, md_busy;
   logic [31:0] stall_cnt;
   logic        stall4, pc_en4, d_en4, e_clr4, br_stall4, md_busy4;
   logic [3:0]  stall_cnt4;

   always #5 clk = ~clk;

   stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .PERF_W(32)) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dest(d_dest), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
      .stall(stall), .pc_en(pc_en), .d_en(d_en), .e_clr(e_clr), .br_stall(br_stall),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4), .PERF_W(4)) dut4 (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dest(d_dest), .d_tnew(d_tnew),
      .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
      .stall(stall4), .pc_en(pc_en4), .d_en(d_en4), .e_clr(e_clr4), .br_stall(br_stall4),
      .md_busy(md_busy4), .stall_cnt(stall_cnt4)
   );

   typedef struct {
      int          tag;
      logic        stall;
      logic        br;
      logic        busy;
      logic [31:0] cnt;
      logic [3:0]  cnt4;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          tag   = 0;
   int          exp_cnt = 0;
   logic        stim_done = 1'b0;

   task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, t, act, req);
      end
   endtask

   // Monitor: outputs are stable by the negedge following each drive.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",      e.tag, {31'd0, stall},    {31'd0, e.stall});
            chk("br_stall",   e.tag, {31'd0, br_stall}, {31'd0, e.br});
            chk("md_busy",    e.tag, {31'd0, md_busy},  {31'd0, e.busy});
            chk("pc_en",      e.tag, {31'd0, pc_en},    {31'd0, !e.stall});
            chk("d_en",       e.tag, {31'd0, d_en},     {31'd0, !e.stall});
            chk("e_clr",      e.tag, {31'd0, e_clr},    {31'd0, e.stall});
            chk("stall_cnt",  e.tag, stall_cnt,         e.cnt);
            chk("stall_cnt4", e.tag, {28'd0, stall_cnt4}, {28'd0, e.cnt4});
         end
      end
   end

   // Drive one D instruction for one cycle and push the expected outputs.
   task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] ur, input logic [1:0] ut,
                      input logic [4:0] dst, input logic [1:0] tn,
                      input logic mds, input logic mdd, input logic mdu,
                      input logic es, input logic eb, input logic ebusy);
      exp_t e;
      d_valid = v;  d_rs = rs;  d_rt = rt;  d_tuse_rs = ur;  d_tuse_rt = ut;
      d_dest = dst; d_tnew = tn; d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
      e.tag = tag; e.stall = es; e.br = eb; e.busy = ebusy;
      e.cnt = exp_cnt; e.cnt4 = (exp_cnt > 15) ? 4'd15 : exp_cnt[3:0];
      exp_q.push_back(e);
      tag++;
      if (reset) exp_cnt = 0;
      else if (es) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input logic ebusy);
      cyc(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ebusy);
   endtask

   // mfhi/mflo-style reader of HI/LO: writes $t2, no GPR sources
   task automatic mflo(input logic es, input logic ebusy);
      cyc(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1, es, 1'b0, ebusy);
   endtask

   task automatic md_start(input logic div);
      cyc(1'b1, 5'd8, 5'd9, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, div, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      d_valid = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = '0; d_tuse_rt = '0;
      d_dest = '0; d_tnew = '0; d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
      @(posedge clk);
      #1;
      nop(1'b0);                         // reset state
      reset = 1'b0;

      // lw $t0 then beq $t0,$t1: two branch stalls
      cyc(1, 5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 1, 1, 0);
      cyc(1, 5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 1, 1, 0);
      cyc(1, 5'd8, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);

      // addu $t0 then beq on $t0: one stall
      cyc(1, 5'd10, 5'd11, 2'd1, 2'd1, 5'd8, 2'd1, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 0, 0, 0, 1, 1, 0);
      cyc(1, 5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);

      // addu $t0 then sw of $t0: no stall
      cyc(1, 5'd10, 5'd11, 2'd1, 2'd1, 5'd8, 2'd1, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd29, 5'd8, 2'd1, 2'd2, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);

      // lw $t0 then addu using $t0 in E: one stall, not a branch stall
      cyc(1, 5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd8, 5'd12, 2'd1, 2'd1, 5'd13, 2'd1, 0, 0, 0, 1, 0, 0);
      cyc(1, 5'd8, 5'd12, 2'd1, 2'd1, 5'd13, 2'd1, 0, 0, 0, 0, 0, 0);

      // lw $t1, unrelated instr, beq on rt=$t1: hazard against M
      cyc(1, 5'd29, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd14, 5'd15, 2'd1, 2'd1, 5'd16, 2'd1, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd0, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 1, 1, 0);
      cyc(1, 5'd0, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);

      // addu $0 then beq $0,$0: no stall
      cyc(1, 5'd10, 5'd11, 2'd1, 2'd1, 5'd0, 2'd1, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);

      // lw $t0 then invalid D with matching fields, then tuse 3 on $t0
      cyc(1, 5'd29, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 0, 0, 0, 0, 0, 0);
      cyc(0, 5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);
      cyc(1, 5'd8, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);
      nop(0);
      nop(0);

      // mult then mflo: 1 + 5 stall cycles
      md_start(1'b0);
      for (int i = 0; i < 6; i++) mflo(1'b1, i > 0);
      mflo(1'b0, 1'b0);

      // div then mfhi: 1 + 10 stall cycles
      md_start(1'b1);
      for (int i = 0; i < 11; i++) mflo(1'b1, i > 0);
      mflo(1'b0, 1'b0);

      // div, reset three cycles into busy, then mflo issues freely
      md_start(1'b1);
      nop(1'b0);
      nop(1'b1);
      nop(1'b1);
      nop(1'b1);
      reset = 1'b1;
      mflo(1'b0, 1'b0);
      reset = 1'b0;
      mflo(1'b0, 1'b0);
      mflo(1'b0, 1'b0);

      // two div+mflo runs: 22 stalls, 4-bit counter holds at 15
      for (int r = 0; r < 2; r++) begin
         md_start(1'b1);
         for (int i = 0; i < 11; i++) mflo(1'b1, i > 0);
         mflo(1'b0, 1'b0);
      end
      nop(1'b0);

      stim_done = 1'b1;
      repeat (3) @(posedge clk);
      chk("queue_drained", tag, exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time bound in case the stimulus process ever stalls.
   initial begin
      #200000;
      if (!stim_done) begin
         $display("FAIL timeout vec=%0d actual=running required=done", tag);
         $fatal(1, "timeout");
      end
   end

endmodule
